// File: rtl/pwm_decoder_pkg.sv
// Shared types and defaults for the pwm_decoder block.
package pwm_pkg;

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } pwm_state_t;

  localparam int DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/pwm_input_sync.sv
// Input conditioning for pwm_decoder: 2-flop synchronizer, optional deglitch filter
// (PWM_DECODER_GLITCH_FILTER_EN) and rise/fall detection on the conditioned level.
module pwm_input_sync #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic i_pwm,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int ARM_LAT = 3 + FILTER_LEN;
  localparam int AW      = $clog2(ARM_LAT + 1);
  localparam logic [AW-1:0] ARM_MAX = AW'(ARM_LAT);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_prev;
  logic [AW-1:0] r_arm_cnt;
  logic          w_level;
  logic          w_armed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_prev    <= 1'b0;
      r_arm_cnt <= '0;
    end else begin
      r_sync1 <= i_pwm;
      r_sync2 <= r_sync1;
      r_prev  <= w_level;
      if (r_arm_cnt != ARM_MAX) r_arm_cnt <= r_arm_cnt + 1'b1;
    end
  end

  // Edges are suppressed until the pipeline holds real input, so a line that is
  // already high when reset releases does not look like a fresh rising edge.
  assign w_armed = (r_arm_cnt == ARM_MAX);

`ifdef PWM_DECODER_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);

  logic [FW-1:0] r_flt_cnt;
  logic          r_flt_level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flt_cnt   <= '0;
      r_flt_level <= 1'b0;
    end else if (r_sync2 == r_flt_level) begin
      r_flt_cnt <= '0;
    end else if (r_flt_cnt == FLT_LAST) begin
      r_flt_level <= r_sync2;
      r_flt_cnt   <= '0;
    end else begin
      r_flt_cnt <= r_flt_cnt + 1'b1;
    end
  end

  assign w_level = r_flt_level;
`else
  assign w_level = r_sync2;
`endif

  assign o_level = w_level;
  assign o_rise  = w_armed & w_level & ~r_prev;
  assign o_fall  = w_armed & ~w_level & r_prev;

endmodule

// File: rtl/pwm_decoder.sv
// pwm_decoder: measures high time and period of an asynchronous PWM input, one
// latest-wins measurement per period. Optional deglitch: PWM_DECODER_GLITCH_FILTER_EN.
module pwm_decoder
  import pwm_pkg::*;
#(
  parameter int PWM_WIDTH      = 8,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int FILTER_LEN     = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_pwm,
  output logic [PWM_WIDTH-1:0] o_duty,
  output logic [CNT_WIDTH-1:0] o_period,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_timeout,
  output logic                 o_level,
  output logic                 o_overrun
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] TO_CNT   = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] DUTY_MAX = CNT_WIDTH'({PWM_WIDTH{1'b1}});

  pwm_state_t           r_state;
  logic [CNT_WIDTH-1:0] r_high_cnt;
  logic [CNT_WIDTH-1:0] r_per_cnt;
  logic [CNT_WIDTH-1:0] r_period;
  logic [PWM_WIDTH-1:0] r_duty;
  logic                 r_valid;
  logic                 r_timeout;
  logic                 r_overrun;

  logic                 w_level;
  logic                 w_rise;
  logic                 w_fall;
  logic [CNT_WIDTH-1:0] w_high_inc;
  logic [CNT_WIDTH-1:0] w_per_inc;
  logic [PWM_WIDTH-1:0] w_duty_sat;
  logic                 w_timeout_hit;

  pwm_input_sync #(
    .FILTER_LEN(FILTER_LEN)
  ) u_input_sync (
    .clk    (clk),
    .reset  (reset),
    .i_pwm  (i_pwm),
    .o_level(w_level),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  assign w_high_inc    = (r_high_cnt == CNT_MAX) ? r_high_cnt : r_high_cnt + CNT_ONE;
  assign w_per_inc     = (r_per_cnt == CNT_MAX) ? r_per_cnt : r_per_cnt + CNT_ONE;
  assign w_duty_sat    = (r_high_cnt > DUTY_MAX) ? {PWM_WIDTH{1'b1}} : r_high_cnt[PWM_WIDTH-1:0];
  assign w_timeout_hit = (r_per_cnt >= TO_CNT);

  // S_SYNC: await rise, no output | S_HIGH: count high+period | S_LOW: count period, rise closes it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_SYNC;
      r_high_cnt <= '0;
      r_per_cnt  <= '0;
      r_duty     <= '0;
      r_period   <= '0;
      r_valid    <= 1'b0;
      r_timeout  <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (r_valid && i_ready) r_valid <= 1'b0;

      case (r_state)
        S_SYNC: begin
          // The edge cycle is the first cycle of the new high phase.
          if (w_rise) begin
            r_state    <= S_HIGH;
            r_high_cnt <= CNT_ONE;
            r_per_cnt  <= CNT_ONE;
            r_timeout  <= 1'b0;
          end
        end
        S_HIGH: begin
          if (w_timeout_hit) begin
            r_state   <= S_SYNC;
            r_timeout <= 1'b1;
          end else if (w_fall) begin
            r_state   <= S_LOW;
            r_per_cnt <= w_per_inc;
          end else begin
            r_high_cnt <= w_high_inc;
            r_per_cnt  <= w_per_inc;
          end
        end
        S_LOW: begin
          if (w_timeout_hit) begin
            r_state   <= S_SYNC;
            r_timeout <= 1'b1;
          end else if (w_rise) begin
            r_duty     <= w_duty_sat;
            r_period   <= r_per_cnt;
            r_valid    <= 1'b1;
            r_overrun  <= r_valid && !i_ready;
            r_high_cnt <= CNT_ONE;
            r_per_cnt  <= CNT_ONE;
            r_state    <= S_HIGH;
          end else begin
            r_per_cnt <= w_per_inc;
          end
        end
        default: r_state <= S_SYNC;
      endcase
    end
  end

  assign o_duty    = r_duty;
  assign o_period  = r_period;
  assign o_valid   = r_valid;
  assign o_timeout = r_timeout;
  assign o_overrun = r_overrun;
  assign o_level   = w_level;

endmodule

// File: tb/tb_pwm_decoder.sv
// Self-checking bench for pwm_decoder: clk-synchronous PWM patterns checked against
// a per-pulse reference model (duty = min(high,255), period = high+low).
module tb_pwm_decoder;

  localparam int PW   = 8;
  localparam int CW   = 16;
  localparam int TO   = 1024;
  localparam int FLEN = 3;
`ifdef PWM_DECODER_GLITCH_FILTER_EN
  localparam int LAT  = 3 + FLEN;
  localparam int MINP = FLEN;
`else
  localparam int LAT  = 3;
  localparam int MINP = 1;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          i_pwm;
  logic          i_ready;
  logic [PW-1:0] o_duty;
  logic [CW-1:0] o_period;
  logic          o_valid;
  logic          o_timeout;
  logic          o_level;
  logic          o_overrun;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_ovr   = 0;
  int tmo_clr_cyc = -1;
  logic tmo_q = 1'b0;
  int got_d[$];
  int got_p[$];
  int got_c[$];
  int drv_rise[$];

  pwm_decoder #(
    .PWM_WIDTH(PW), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO), .FILTER_LEN(FLEN)
  ) dut (
    .clk(clk), .reset(reset), .i_pwm(i_pwm), .o_duty(o_duty), .o_period(o_period),
    .o_valid(o_valid), .i_ready(i_ready), .o_timeout(o_timeout), .o_level(o_level),
    .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && o_valid && i_ready) begin
      got_d.push_back(int'(o_duty));
      got_p.push_back(int'(o_period));
      got_c.push_back(cyc);
    end
    if (o_overrun) n_ovr <= n_ovr + 1;
    tmo_q <= o_timeout;
    if (tmo_q && !o_timeout) tmo_clr_cyc <= cyc;
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: cycles=%0d limit=90000", cyc);
    $fatal(1, "watchdog expired");
  end

  function automatic int sat_duty(int h);
    return (h > 255) ? 255 : h;
  endfunction

  task automatic set_for(input logic v, input int n);
    @(posedge clk);
    #1;
    if (v && !i_pwm) drv_rise.push_back(cyc);
    i_pwm = v;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic drive_pulse(input int h, input int l);
    set_for(1'b1, h);
    set_for(1'b0, l);
  endtask

  task automatic close_period(input int hc);
    set_for(1'b1, hc);
    set_for(1'b0, 1);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1; i_pwm = 1'b0; i_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (12) @(posedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    n_tests++; if (o_duty !== 8'd0)     begin n_fail++; $display("FAIL reset_duty: got %0d want 0", o_duty); end
    n_tests++; if (o_period !== 16'd0)  begin n_fail++; $display("FAIL reset_period: got %0d want 0", o_period); end
    n_tests++; if (o_valid !== 1'b0)    begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    n_tests++; if (o_timeout !== 1'b0)  begin n_fail++; $display("FAIL reset_timeout: got %b want 0", o_timeout); end
    n_tests++; if (o_overrun !== 1'b0)  begin n_fail++; $display("FAIL reset_overrun: got %b want 0", o_overrun); end
    n_tests++; if (o_level !== 1'b0)    begin n_fail++; $display("FAIL reset_level: got %b want 0", o_level); end
  endtask

  // Drives a pulse list from S_SYNC and checks every closed period plus latency.
  task automatic run_list(input string nm, input int hs[$], input int ls[$]);
    int g0, r0;
    apply_reset();
    g0 = got_d.size(); r0 = drv_rise.size();
    foreach (hs[k]) drive_pulse(hs[k], ls[k]);
    close_period(MINP);
    repeat (LAT + 5) @(posedge clk);
    n_tests++;
    if (got_d.size() - g0 !== hs.size()) begin
      n_fail++; $display("FAIL %s_count: got %0d want %0d", nm, got_d.size() - g0, hs.size());
    end
    foreach (hs[k]) begin
      n_tests++;
      if (g0 + k >= got_d.size()) begin
        n_fail++; $display("FAIL %s_meas[%0d]: missing, want duty=%0d period=%0d", nm, k, sat_duty(hs[k]), hs[k] + ls[k]);
      end else if (got_d[g0+k] !== sat_duty(hs[k]) || got_p[g0+k] !== hs[k] + ls[k]
                   || got_c[g0+k] !== drv_rise[r0+k+1] + LAT) begin
        n_fail++;
        $display("FAIL %s_meas[%0d]: got duty=%0d period=%0d cyc=%0d want duty=%0d period=%0d cyc=%0d", nm, k,
                 got_d[g0+k], got_p[g0+k], got_c[g0+k], sat_duty(hs[k]), hs[k] + ls[k], drv_rise[r0+k+1] + LAT);
      end
    end
  endtask

  task automatic test_basic();
    int hs[$], ls[$];
    for (int k = 0; k < 4; k++) begin hs.push_back(128); ls.push_back(128); end
    run_list("basic", hs, ls);
  endtask

  task automatic test_extremes();
    int hs[$], ls[$];
    hs = '{MINP, MINP, 256 - MINP, 256 - MINP};
    ls = '{256 - MINP, 256 - MINP, MINP, MINP};
    run_list("extreme", hs, ls);
  endtask

  task automatic test_random();
    int hs[$], ls[$];
    for (int k = 0; k < 12; k++) begin
      hs.push_back(int'($urandom_range(300, MINP)));
      ls.push_back(int'($urandom_range(300, MINP)));
    end
    run_list("random", hs, ls);
  endtask

  task automatic test_overrun();
    int g0, o0;
    apply_reset();
    i_ready = 1'b0;
    g0 = got_d.size(); o0 = n_ovr;
    drive_pulse(64, 192);
    drive_pulse(96, 160);
    drive_pulse(32, 224);
    set_for(1'b1, LAT + 6);
    @(negedge clk);
    n_tests++; if (n_ovr - o0 !== 2) begin n_fail++; $display("FAIL ovr_pulses: got %0d want 2", n_ovr - o0); end
    n_tests++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid_hold: got %b want 1", o_valid); end
    n_tests++;
    if (o_duty !== 8'd32 || o_period !== 16'd256) begin
      n_fail++; $display("FAIL ovr_held: got duty=%0d period=%0d want duty=32 period=256", o_duty, o_period);
    end
    @(posedge clk); #1 i_ready = 1'b1;
    repeat (4) @(posedge clk);
    set_for(1'b0, 5);
    n_tests++;
    if (got_d.size() - g0 !== 1) begin
      n_fail++; $display("FAIL ovr_handshakes: got %0d want 1", got_d.size() - g0);
    end else if (got_d[g0] !== 32 || got_p[g0] !== 256) begin
      n_fail++; $display("FAIL ovr_accepted: got duty=%0d period=%0d want duty=32 period=256", got_d[g0], got_p[g0]);
    end
    n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_valid_clear: got %b want 0", o_valid); end
  endtask

  task automatic test_timeout();
    int r, q, g0, n0;
    apply_reset();
    g0 = got_d.size();
    drive_pulse(100, 156);
    drive_pulse(100, 156);
    close_period(MINP);
    r = drv_rise[$];
    wait_cyc(r + LAT + 5);
    n0 = got_d.size();
    n_tests++; if (n0 - g0 !== 2) begin n_fail++; $display("FAIL tmo_pre_meas: got %0d want 2", n0 - g0); end
    wait_cyc(r + LAT + TO - 1);
    n_tests++; if (o_timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got %b want 0", o_timeout); end
    wait_cyc(r + LAT + TO + MINP + 1);
    n_tests++; if (o_timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_assert: got %b want 1", o_timeout); end
    n_tests++; if (o_level !== 1'b0) begin n_fail++; $display("FAIL tmo_level: got %b want 0", o_level); end
    n_tests++; if (got_d.size() !== n0 || o_valid !== 1'b0) begin
      n_fail++; $display("FAIL tmo_no_valid: got %0d extra, valid=%b want 0 extra, valid=0", got_d.size() - n0, o_valid);
    end
    repeat (20) @(posedge clk);
    drive_pulse(100, 150);
    q = drv_rise[$ - 0];
    q = drv_rise[drv_rise.size() - 1];
    close_period(MINP);
    repeat (LAT + 5) @(posedge clk);
    n_tests++;
    if (tmo_clr_cyc !== drv_rise[drv_rise.size() - 2] + LAT) begin
      n_fail++; $display("FAIL tmo_clear: got cyc=%0d want cyc=%0d", tmo_clr_cyc, drv_rise[drv_rise.size() - 2] + LAT);
    end
    n_tests++;
    if (got_d.size() - n0 !== 1) begin
      n_fail++; $display("FAIL tmo_resync_count: got %0d want 1", got_d.size() - n0);
    end else if (got_d[n0] !== 100 || got_p[n0] !== 250 || got_c[n0] !== drv_rise[drv_rise.size() - 2] + 250 + LAT) begin
      n_fail++; $display("FAIL tmo_resync_meas: got duty=%0d period=%0d cyc=%0d want duty=100 period=250 cyc=%0d",
                         got_d[n0], got_p[n0], got_c[n0], drv_rise[drv_rise.size() - 2] + 250 + LAT);
    end
    if (q < 0) $display("note: bad rise index");
  endtask

  task automatic test_reset_mid();
    int g0;
    apply_reset();
    i_ready = 1'b0;
    drive_pulse(100, 100);
    set_for(1'b1, LAT + 20);
    @(negedge clk);
    n_tests++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pending: got %b want 1", o_valid); end
    @(posedge clk); #3 reset = 1'b1;
    #1;
    n_tests++;
    if (o_duty !== 8'd0 || o_period !== 16'd0 || o_valid !== 1'b0 || o_timeout !== 1'b0
        || o_overrun !== 1'b0 || o_level !== 1'b0) begin
      n_fail++; $display("FAIL rmid_async_clear: got duty=%0d period=%0d valid=%b tmo=%b ovr=%b lvl=%b want all 0",
                         o_duty, o_period, o_valid, o_timeout, o_overrun, o_level);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; i_ready = 1'b1;
    g0 = got_d.size();
    set_for(1'b1, 40);
    set_for(1'b0, 60);
    n_tests++; if (got_d.size() !== g0) begin n_fail++; $display("FAIL rmid_partial: got %0d meas want 0", got_d.size() - g0); end
    drive_pulse(80, 120);
    drive_pulse(70, 130);
    close_period(MINP);
    repeat (LAT + 5) @(posedge clk);
    n_tests++;
    if (got_d.size() - g0 !== 2) begin
      n_fail++; $display("FAIL rmid_count: got %0d want 2", got_d.size() - g0);
    end else if (got_d[g0] !== 80 || got_p[g0] !== 200 || got_d[g0+1] !== 70 || got_p[g0+1] !== 200) begin
      n_fail++; $display("FAIL rmid_meas: got %0d/%0d %0d/%0d want 80/200 70/200",
                         got_d[g0], got_p[g0], got_d[g0+1], got_p[g0+1]);
    end
  endtask

  task automatic test_glitch();
    int g0, g;
    int ed[$], ep[$];
    apply_reset();
    g0 = got_d.size();
    for (int k = 0; k < 3; k++) begin
      g = int'($urandom_range(120, 5));
      drive_pulse(g, 1);
      drive_pulse(127 - g, 128);
`ifdef PWM_DECODER_GLITCH_FILTER_EN
      ed.push_back(128); ep.push_back(256);
`else
      ed.push_back(g); ep.push_back(g + 1);
      ed.push_back(127 - g); ep.push_back(255 - g);
`endif
    end
    close_period(MINP);
    repeat (LAT + 5) @(posedge clk);
    n_tests++;
    if (got_d.size() - g0 !== ed.size()) begin
      n_fail++; $display("FAIL glitch_count: got %0d want %0d", got_d.size() - g0, ed.size());
    end
    foreach (ed[k]) begin
      n_tests++;
      if (g0 + k >= got_d.size()) begin
        n_fail++; $display("FAIL glitch_meas[%0d]: missing, want duty=%0d period=%0d", k, ed[k], ep[k]);
      end else if (got_d[g0+k] !== ed[k] || got_p[g0+k] !== ep[k]) begin
        n_fail++; $display("FAIL glitch_meas[%0d]: got duty=%0d period=%0d want duty=%0d period=%0d",
                           k, got_d[g0+k], got_p[g0+k], ed[k], ep[k]);
      end
    end
  endtask

  initial begin
    reset = 1'b1; i_pwm = 1'b0; i_ready = 1'b1;
    test_reset();
    test_basic();
    test_extremes();
    test_random();
    test_overrun();
    test_timeout();
    test_reset_mid();
    test_glitch();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
